imm_ext_ctrl: RTL and testbench

//  Decode-stage immediate controller. Takes fetched instructions over a valid/ready handshake, selects

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/imm_ext.sv | 18 +
 rtl/imm_ext_ctrl.sv | 92 +++++++++
 tb/tb_imm_ext_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode-stage types: opcodes, extension modes and the buffered entry layout.
package cpu_pkg;
  localparam int XLEN  = 32;
  localparam int IMM_W = 16;

  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {EXT_NONE, EXT_ZERO, EXT_SIGN, EXT_UPPER} ext_mode_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    ext_mode_e       mode;
    logic            is_branch;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
  } dec_entry_t;

  function automatic ext_mode_e decode_mode(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LW, OP_SW, OP_BEQ, OP_BNE:   return EXT_SIGN;
      OP_ANDI, OP_ORI, OP_XORI:       return EXT_ZERO;
      OP_LUI:                         return EXT_UPPER;
      default:                        return EXT_NONE;
    endcase
  endfunction
endpackage

// File: rtl/imm_ext.sv
// Combinational immediate extender; NONE yields zero so non-immediate ops carry no stale bits.
module imm_ext
  import cpu_pkg::*;
(
  input  logic [IMM_W-1:0] imm,
  input  ext_mode_e        mode,
  output logic [XLEN-1:0]  result
);
  always_comb begin
    result = '0;
    case (mode)
      EXT_ZERO:  result = {{(XLEN-IMM_W){1'b0}}, imm};
      EXT_SIGN:  result = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
      EXT_UPPER: result = {imm, {(XLEN-IMM_W){1'b0}}};
      default:   result = '0;
    endcase
  end
endmodule

// File: rtl/imm_ext_ctrl.sv
// Decode-stage immediate controller: decode, extend, branch target, then a 2-entry skid buffer.
module imm_ext_ctrl
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      out_mode,
  output logic            out_is_branch,
  output logic [XLEN-1:0] out_br_target,
  output logic [XLEN-1:0] out_pc
);
  logic [5:0]      opcode;
  ext_mode_e       mode;
  logic            is_br;
  logic [XLEN-1:0] ext_val;
  logic [XLEN-1:0] br_off;
  dec_entry_t      new_entry;
  logic            unused_fields;

  assign opcode        = in_instr[31:26];
  assign mode          = decode_mode(opcode);
  assign is_br         = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign unused_fields = ^in_instr[25:16];

  imm_ext u_ext (
    .imm    (in_instr[IMM_W-1:0]),
    .mode   (mode),
    .result (ext_val)
  );

  // Word offset: sign-extended immediate scaled by 4, wraps mod 2^32.
  assign br_off = {{(XLEN-IMM_W-2){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0], 2'b00};

  always_comb begin
    new_entry           = '0;
    new_entry.imm       = ext_val;
    new_entry.mode      = mode;
    new_entry.is_branch = is_br;
    new_entry.target    = is_br ? (in_pc + 32'd4 + br_off) : '0;
    new_entry.pc        = in_pc;
  end

  dec_entry_t [1:0] mem;
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic             push, pop;
  dec_entry_t       head;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head          = out_valid ? mem[rd_ptr] : '0;
  assign out_imm       = head.imm;
  assign out_mode      = head.mode;
  assign out_is_branch = head.is_branch;
  assign out_br_target = head.target;
  assign out_pc        = head.pc;
endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Bench for imm_ext_ctrl: decode table, backpressure/flush/reset sequences, random traffic vs queue model.
module tb_imm_ext_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_imm, out_br_target, out_pc;
  logic [1:0]  out_mode;
  logic        out_is_branch;

  imm_ext_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_mode(out_mode),
    .out_is_branch(out_is_branch), .out_br_target(out_br_target), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  mode;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic [31:0] instr, pc, imm;
    logic [1:0]  mode;
    logic        br;
    logic [31:0] tgt;
  } vec_t;

  ent_t q[$];
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the opcode rules expressed as plain integer arithmetic.
  function automatic ent_t model(input logic [31:0] instr, input logic [31:0] pc);
    ent_t e;
    int   simm;
    int unsigned uimm;
    simm = int'($signed(instr[15:0]));
    uimm = int'(instr[15:0]);
    e.pc = pc; e.br = 1'b0; e.tgt = 32'd0; e.mode = 2'd0; e.imm = 32'd0;
    case (int'(instr[31:26]))
      'h08, 'h09, 'h0A, 'h0B, 'h23, 'h2B: begin e.mode = 2'd2; e.imm = 32'(simm); end
      'h04, 'h05: begin
        e.mode = 2'd2; e.imm = 32'(simm); e.br = 1'b1;
        e.tgt = pc + 32'd4 + 32'(simm * 4);
      end
      'h0C, 'h0D, 'h0E: begin e.mode = 2'd1; e.imm = uimm; end
      'h0F: begin e.mode = 2'd3; e.imm = uimm * 32'd65536; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic compare(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
    if (q.size() != 0) begin
      chk({tag, ".imm"},  out_imm,              q[0].imm);
      chk({tag, ".mode"}, 32'(out_mode),        32'(q[0].mode));
      chk({tag, ".br"},   32'(out_is_branch),   32'(q[0].br));
      chk({tag, ".tgt"},  out_br_target,        q[0].tgt);
      chk({tag, ".pc"},   out_pc,               q[0].pc);
    end else begin
      chk({tag, ".idle_data"}, out_imm | out_br_target | out_pc | 32'(out_mode) | 32'(out_is_branch), 32'd0);
    end
  endtask

  // Called at a negedge: drive inputs, advance one clock in DUT and model, compare at next negedge.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input string tag);
    logic push, pop;
    ent_t e;
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    push = iv && (q.size() < 2);
    pop  = (q.size() != 0) && ordy;
    e = model(ins, pc);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    @(negedge clk);
    compare(tag);
  endtask

  vec_t        vecs[11];
  logic [5:0]  ops[16];

  initial begin
    vecs[0]  = '{32'h30008000, 32'h0,        32'h00008000, 2'd1, 1'b0, 32'h0};
    vecs[1]  = '{32'h20008000, 32'h4,        32'hFFFF8000, 2'd2, 1'b0, 32'h0};
    vecs[2]  = '{32'h3C001234, 32'h8,        32'h12340000, 2'd3, 1'b0, 32'h0};
    vecs[3]  = '{32'h00221820, 32'hC,        32'h0,        2'd0, 1'b0, 32'h0};
    vecs[4]  = '{32'h1000FFFF, 32'h100,      32'hFFFFFFFF, 2'd2, 1'b1, 32'h00000100};
    vecs[5]  = '{32'h10000000, 32'hFFFFFFFC, 32'h0,        2'd2, 1'b1, 32'h00000000};
    vecs[6]  = '{32'h14000010, 32'h2000,     32'h00000010, 2'd2, 1'b1, 32'h00002044};
    vecs[7]  = '{32'h14008000, 32'h0,        32'hFFFF8000, 2'd2, 1'b1, 32'hFFFE0004};
    vecs[8]  = '{32'hAC00FFF0, 32'h40,       32'hFFFFFFF0, 2'd2, 1'b0, 32'h0};
    vecs[9]  = '{32'h3400ABCD, 32'h44,       32'h0000ABCD, 2'd1, 1'b0, 32'h0};
    vecs[10] = '{32'hFC001234, 32'h48,       32'h0,        2'd0, 1'b0, 32'h0};
    ops = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
            6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h01, 6'h10};

    @(negedge clk); @(negedge clk);
    compare("reset");
    rst_n = 1'b1;
    @(negedge clk);
    compare("post_reset");

    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].instr, vecs[i].pc, 1'b1, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_imm", i),  out_imm,            vecs[i].imm);
      chk($sformatf("vec%0d.tbl_mode", i), 32'(out_mode),      32'(vecs[i].mode));
      chk($sformatf("vec%0d.tbl_br", i),   32'(out_is_branch), 32'(vecs[i].br));
      chk($sformatf("vec%0d.tbl_tgt", i),  out_br_target,      vecs[i].tgt);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain");
    end

    // Backpressure: A,B fill the buffer, C waits upstream, then all drain in order.
    cycle(1'b1, 32'h20000001, 32'hA0, 1'b0, 1'b0, "bp_a");
    cycle(1'b1, 32'h20000002, 32'hB0, 1'b0, 1'b0, "bp_b");
    chk("bp.full_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 32'h20000003, 32'hC0, 1'b0, 1'b0, "bp_hold");
    chk("bp.hold_pc", out_pc, 32'hA0);
    cycle(1'b1, 32'h20000003, 32'hC0, 1'b1, 1'b0, "bp_pop_a");
    chk("bp.second_pc", out_pc, 32'hB0);
    cycle(1'b1, 32'h20000003, 32'hC0, 1'b1, 1'b0, "bp_pop_b");
    chk("bp.third_pc", out_pc, 32'hC0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "bp_pop_c");
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Flush at count 2 with a same-cycle push: everything discarded.
    cycle(1'b1, 32'h30000011, 32'h200, 1'b0, 1'b0, "fl_a");
    cycle(1'b1, 32'h30000022, 32'h204, 1'b0, 1'b0, "fl_b");
    cycle(1'b1, 32'h30000033, 32'h208, 1'b0, 1'b1, "fl_flush");
    chk("fl.out_valid", 32'(out_valid), 32'd0);
    chk("fl.in_ready",  32'(in_ready),  32'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "fl_after");
    chk("fl.never_emitted", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-traffic.
    cycle(1'b1, 32'h3C00BEEF, 32'h300, 1'b0, 1'b0, "rst_a");
    cycle(1'b1, 32'h3C00CAFE, 32'h304, 1'b0, 1'b0, "rst_b");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    chk("async_rst.in_ready",  32'(in_ready),  32'd1);
    chk("async_rst.out_imm",   out_imm,        32'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare("after_rst");

    repeat (600) begin
      logic [31:0] r, p;
      logic [5:0]  op;
      r  = $urandom;
      p  = $urandom & 32'hFFFF_FFFC;
      op = ops[$urandom_range(0, 15)];
      cycle($urandom_range(0, 3) != 0, {op, r[25:0]}, p,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
